// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, word width and opcode/func codes
// used by both the fetch unit and the instruction decoder.
package cpu_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] OP_J         = 6'h02;
  localparam logic [5:0] OP_JAL       = 6'h03;
  localparam logic [5:0] OP_BEQ       = 6'h04;
  localparam logic [5:0] OP_BNE       = 6'h05;
  localparam logic [5:0] FUNC_JR      = 6'h08;
  localparam logic [5:0] FUNC_SYSCALL = 6'h0C;

  localparam logic [INSTR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: pc+4, branch/jump/jr targets and the
// halted > jump_register > jump > branch > sequential priority mux.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  logic [25:0]        imm26,
  input  logic [INSTR_W-1:0] rs_data,
  input  logic               halted,
  input  logic               jump,
  input  logic               jump_register,
  input  logic               branch,
  output logic [INSTR_W-1:0] pc4,
  output logic [INSTR_W-1:0] next_pc
);

  logic [INSTR_W-1:0] branch_target;
  logic [INSTR_W-1:0] jump_target;
  logic [INSTR_W-1:0] jr_target;

  assign pc4           = pc + 32'd4;
  assign branch_target = pc4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign jump_target   = {pc4[31:28], imm26, 2'b00};
  // JR targets with stray low bits are word-aligned rather than faulted.
  assign jr_target     = rs_data & WORD_MASK;

  always_comb begin
    next_pc = pc4;
    if (halted)             next_pc = pc;
    else if (jump_register) next_pc = jr_target;
    else if (jump)          next_pc = jump_target;
    else if (branch)        next_pc = branch_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencing stage: FSM, pc/inst registers, ack timeout.
// Build option: define JAL_LINK_PC8_EN for link_addr = pc+8 (else pc+4).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ACK_TMO  = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] inst,
  output logic               inst_valid,
  input  logic               ex_done,
  input  logic               halted,
  input  logic               jump,
  input  logic               jump_register,
  input  logic               branch,
  input  logic [INSTR_W-1:0] rs_data,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] link_addr,
  output logic               halt,
  output logic               fetch_err
);

  // state | meaning
  // FETCH | imem_req high at pc, waiting for imem_ack
  // EXEC  | inst held for decode/execute until ex_done
  // HALT  | sticky SYSCALL halt, left only by rst
  // ERR   | sticky ack timeout, left only by rst

  localparam logic [15:0] TMO_LOAD = (ACK_TMO == 0) ? 16'd0 : 16'(ACK_TMO - 1);

  fetch_state_t       state, state_nxt;
  logic               started;
  logic [15:0]        wait_cnt;
  logic               tmo_hit;
  logic [INSTR_W-1:0] pc4;
  logic [INSTR_W-1:0] next_pc;

  next_pc_calc u_next_pc (
    .pc            (pc),
    .imm26         (inst[25:0]),
    .rs_data       (rs_data),
    .halted        (halted),
    .jump          (jump),
    .jump_register (jump_register),
    .branch        (branch),
    .pc4           (pc4),
    .next_pc       (next_pc)
  );

  // started holds off the first request until one cycle after reset release.
  assign imem_req   = started && (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == EXEC);
  assign halt       = (state == HALT);
  assign fetch_err  = (state == ERR);
  assign tmo_hit    = (ACK_TMO != 0) && (wait_cnt == 16'd0);

`ifdef JAL_LINK_PC8_EN
  assign link_addr = pc + 32'd8;
`else
  assign link_addr = pc4;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (imem_req) begin
          if (imem_ack)     state_nxt = EXEC;
          else if (tmo_hit) state_nxt = ERR;
        end
      end
      EXEC: begin
        if (ex_done) state_nxt = halted ? HALT : FETCH;
      end
      HALT:    state_nxt = HALT;
      ERR:     state_nxt = ERR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      started  <= 1'b0;
      pc       <= RESET_PC;
      inst     <= '0;
      wait_cnt <= TMO_LOAD;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      if (imem_req && imem_ack) begin
        inst     <= imem_rdata;
        wait_cnt <= TMO_LOAD;
      end else if (imem_req && (wait_cnt != 16'd0)) begin
        wait_cnt <= wait_cnt - 16'd1;
      end
      if ((state == EXEC) && ex_done) pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of the PC/inst
// sequence, directed corner cases and randomized handshakes/redirects.
module tb_fetch_unit;

  localparam int unsigned TMO = 4;
`ifdef JAL_LINK_PC8_EN
  localparam logic [31:0] LINK_OFF = 32'd8;
`else
  localparam logic [31:0] LINK_OFF = 32'd4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] inst, pc, link_addr, rs_data = '0;
  logic        inst_valid, ex_done = 1'b0;
  logic        halted = 1'b0, jump = 1'b0, jump_register = 1'b0, branch = 1'b0;
  logic        halt, fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .ACK_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .ex_done(ex_done), .halted(halted),
    .jump(jump), .jump_register(jump_register), .branch(branch),
    .rs_data(rs_data), .pc(pc), .link_addr(link_addr), .halt(halt),
    .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Model phase: 0 waiting for first request, 1 fetching, 2 executing, 3 halted, 4 timed out.
  int          m_phase;
  int          m_wcnt;
  logic [31:0] m_pc, m_inst;
  bit          m_halt, m_err;

  bit          s_ack, s_done, s_halted, s_jump, s_jr, s_branch;
  logic [31:0] s_rs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
    chk("inst_valid", 32'(inst_valid), 32'(m_phase == 2));
    chk("pc", pc, m_pc);
    chk("link_addr", link_addr, m_pc + LINK_OFF);
    chk("halt", 32'(halt), 32'(m_halt));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    if (m_phase == 1) chk("imem_addr", imem_addr, m_pc);
    if (m_phase == 0 || m_phase == 2) chk("inst", inst, m_inst);
  endtask

  task automatic model_reset();
    m_phase = 0; m_wcnt = 0; m_pc = 32'h0; m_inst = 32'h0; m_halt = 0; m_err = 0;
  endtask

  // Advance the model across one rising edge using the stimulus now applied.
  task automatic model_edge();
    logic [31:0] pc4;
    int          off;
    pc4 = m_pc + 32'd4;
    case (m_phase)
      0: m_phase = 1;
      1: begin
        if (s_ack) begin
          m_inst = mem_word(m_pc); m_phase = 2; m_wcnt = 0;
        end else begin
          m_wcnt++;
          if (m_wcnt == int'(TMO)) begin m_phase = 4; m_err = 1; end
        end
      end
      2: begin
        if (s_done) begin
          if (s_halted) begin
            m_phase = 3; m_halt = 1;
          end else begin
            off = int'($signed(m_inst[15:0]));
            if (s_jr)          m_pc = s_rs & 32'hFFFF_FFFC;
            else if (s_jump)   m_pc = (pc4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2);
            else if (s_branch) m_pc = pc4 + 32'(off * 4);
            else               m_pc = pc4;
            m_phase = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Called at a falling edge: check, drive, predict, move to the next falling edge.
  task automatic cycle();
    check_outputs();
    imem_ack      = s_ack;
    imem_rdata    = s_ack ? mem_word(imem_addr) : $urandom;
    ex_done       = s_done;
    halted        = s_halted;
    jump          = s_jump;
    jump_register = s_jr;
    branch        = s_branch;
    rs_data       = s_rs;
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; ex_done = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_instr(input bit h, input bit j, input bit jr, input bit b, input logic [31:0] rs);
    bit fin = 0;
    for (int i = 0; i < 10 && !fin; i++) begin
      int ph = m_phase;
      s_ack = (ph == 1); s_done = (ph == 2);
      s_halted = h; s_jump = j; s_jr = jr; s_branch = b; s_rs = rs;
      cycle();
      if (ph == 2) fin = 1;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_instr_bound phase=%0d expected instruction to complete", m_phase);
    end
  endtask

  initial begin
    mem_ovr[32'h0000_0040] = 32'h0000_FFFE;
    mem_ovr[32'h1000_0010] = 32'h0000_0100;
    s_ack = 0; s_done = 0; s_halted = 0; s_jump = 0; s_jr = 0; s_branch = 0; s_rs = 0;
    @(negedge clk);
    do_reset();
    chk("lit_reset_pc", pc, 32'h0);

    // Sequential fetch 0,4,8
    run_instr(0, 0, 0, 0, 0);
    chk("lit_seq_addr4", imem_addr, 32'h4);
    run_instr(0, 0, 0, 0, 0);
    chk("lit_seq_addr8", imem_addr, 32'h8);

    // Backward branch and fall-through at 0x40
    run_instr(0, 0, 1, 0, 32'h40);
    run_instr(0, 0, 0, 1, 0);
    chk("lit_branch_taken", pc, 32'h3C);
    run_instr(0, 0, 1, 0, 32'h40);
    run_instr(0, 0, 0, 0, 0);
    chk("lit_branch_not_taken", pc, 32'h44);

    // Wrap and link address
    run_instr(0, 0, 1, 0, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 0, 0);
    chk("lit_wrap", pc, 32'h0);
    run_instr(0, 0, 1, 0, 32'h100);
    s_ack = 1; s_done = 0; cycle();
    chk("lit_link", link_addr, 32'h100 + LINK_OFF);
    run_instr(0, 0, 0, 0, 0);

    // Priority: jr with misaligned target, then jump over branch, jr over jump, halt over all
    run_instr(0, 0, 1, 0, 32'h1000_0013);
    chk("lit_jr_align", pc, 32'h1000_0010);
    run_instr(0, 1, 0, 1, 32'h2003);
    chk("lit_jump_over_branch", pc, 32'h1000_0400);
    run_instr(0, 0, 1, 0, 32'h1000_0010);
    run_instr(0, 1, 1, 1, 32'h2003);
    chk("lit_jr_over_jump", pc, 32'h2000);
    run_instr(0, 0, 1, 0, 32'h1000_0010);
    run_instr(1, 1, 1, 1, 32'h2003);
    chk("lit_halt", 32'(halt), 32'h1);
    chk("lit_halt_pc", pc, 32'h1000_0010);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; s_done = 1; cycle();
    end

    // Randomized handshakes, redirects and occasional halts
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 3) do_reset();
      s_ack    = (m_wcnt == int'(TMO) - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      s_done   = 1'($urandom_range(0, 1));
      s_halted = ($urandom_range(0, 59) == 0);
      s_jump   = 1'($urandom_range(0, 1));
      s_jr     = ($urandom_range(0, 3) == 0);
      s_branch = 1'($urandom_range(0, 1));
      s_rs     = $urandom;
      cycle();
    end

    // Async reset while an instruction is held in EXEC
    if (m_phase == 3) do_reset();
    for (int i = 0; i < 10 && m_phase != 2; i++) begin
      s_ack = (m_wcnt < int'(TMO) - 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_done = 0; s_halted = 0; cycle();
    end
    chk("exec_reached", 32'(inst_valid), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("lit_midexec_pc", pc, 32'h0);
    chk("lit_midexec_valid", 32'(inst_valid), 32'h0);
    chk("lit_midexec_req", 32'(imem_req), 32'h0);
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ack timeout: never acknowledge
    for (int i = 0; i < 6; i++) begin
      s_ack = 0; s_done = 0; cycle();
    end
    chk("lit_tmo_err", 32'(fetch_err), 32'h1);
    chk("lit_tmo_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; s_done = 1; cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
